// File: rtl/mem_wb_writeback.sv
// MEM/WB writeback stage: selects among ALU result, load data, link value and
// immediate, registers the chosen value and drives the register-file write
// port and the forwarding unit. Loads wait in WAIT_MEM for the data memory.
module mem_wb_writeback #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      InValid,
    output logic                      InReady,
    input  logic                      Flush,
    input  logic [1:0]                WbSel,
    input  logic [1:0]                LoadSize,
    input  logic                      LoadUnsigned,
    input  logic [1:0]                ByteOffset,
    input  logic [DATA_WIDTH-1:0]     Result,
    input  logic [DATA_WIDTH-1:0]     PcPlus4,
    input  logic [DATA_WIDTH-1:0]     Imm,
    input  logic                      RegWrite,
    input  logic [REG_ADDR_WIDTH-1:0] WriteReg,
    input  logic                      MemReadValid,
    input  logic [DATA_WIDTH-1:0]     ReadData,
    output logic                      WbValid,
    output logic                      WbRegWrite,
    output logic [REG_ADDR_WIDTH-1:0] WbWriteReg,
    output logic [DATA_WIDTH-1:0]     WbWriteData,
    output logic                      MisalignErr
);

    localparam logic [0:0] IDLE     = 1'b0;
    localparam logic [0:0] WAIT_MEM = 1'b1;

    localparam logic [1:0] SEL_RESULT = 2'b00;
    localparam logic [1:0] SEL_LOAD   = 2'b01;
    localparam logic [1:0] SEL_PC4    = 2'b10;
    localparam logic [1:0] SEL_IMM    = 2'b11;

    logic [0:0]                stateR;
    logic [1:0]                loadSizeR;
    logic                      loadUnsignedR;
    logic [1:0]                byteOffsetR;
    logic                      regWriteR;
    logic [REG_ADDR_WIDTH-1:0] writeRegR;

    logic [DATA_WIDTH-1:0]     selDataS;
    logic [DATA_WIDTH-1:0]     loadDataS;
    logic                      misalignS;
    logic                      transferS;

    // Lane-align a load and extend it to the datapath width. The result is
    // pre-filled with the extension bit so no zero-width replication is needed.
    function automatic logic [DATA_WIDTH-1:0] extendLoad(
        input logic [31:0] d,
        input logic [1:0]  size,
        input logic        isUnsigned,
        input logic [1:0]  offset
    );
        logic [31:0]           shifted;
        logic [15:0]           half;
        logic [DATA_WIDTH-1:0] r;
        shifted = d >> {offset, 3'b000};
        half    = offset[1] ? d[31:16] : d[15:0];
        case (size)
            2'b00: begin
                r      = {DATA_WIDTH{shifted[7] & ~isUnsigned}};
                r[7:0] = shifted[7:0];
            end
            2'b01: begin
                r       = {DATA_WIDTH{half[15] & ~isUnsigned}};
                r[15:0] = half;
            end
            default: begin
                // word and the reserved size both load the full 32 bits
                r       = {DATA_WIDTH{d[31] & ~isUnsigned}};
                r[31:0] = d;
            end
        endcase
        return r;
    endfunction

    // A load is misaligned when its address is not a multiple of its size.
    function automatic logic isMisaligned(
        input logic [1:0] size,
        input logic [1:0] offset
    );
        logic m;
        case (size)
            2'b00:   m = 1'b0;
            2'b01:   m = offset[0];
            default: m = (offset != 2'b00);
        endcase
        return m;
    endfunction

    // Handshake is only offered in IDLE and never while reset is held.
    assign InReady   = (stateR == IDLE) && !rst;
    assign transferS = InValid && InReady && !Flush;

    // Non-load source selection and extraction of the held load.
    always_comb begin
        selDataS = Result;
        case (WbSel)
            SEL_RESULT: selDataS = Result;
            SEL_PC4:    selDataS = PcPlus4;
            SEL_IMM:    selDataS = Imm;
            default:    selDataS = Result;
        endcase
        loadDataS = extendLoad(ReadData[31:0], loadSizeR, loadUnsignedR, byteOffsetR);
        misalignS = isMisaligned(loadSizeR, byteOffsetR);
    end

    // State, load capture and registered writeback outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateR        <= IDLE;
            loadSizeR     <= 2'b00;
            loadUnsignedR <= 1'b0;
            byteOffsetR   <= 2'b00;
            regWriteR     <= 1'b0;
            writeRegR     <= {REG_ADDR_WIDTH{1'b0}};
            WbValid       <= 1'b0;
            WbRegWrite    <= 1'b0;
            WbWriteReg    <= {REG_ADDR_WIDTH{1'b0}};
            WbWriteData   <= {DATA_WIDTH{1'b0}};
            MisalignErr   <= 1'b0;
        end else begin
            WbValid     <= 1'b0;
            MisalignErr <= 1'b0;
            case (stateR)
                IDLE: begin
                    if (transferS) begin
                        if (WbSel == SEL_LOAD) begin
                            loadSizeR     <= LoadSize;
                            loadUnsignedR <= LoadUnsigned;
                            byteOffsetR   <= ByteOffset;
                            regWriteR     <= RegWrite;
                            writeRegR     <= WriteReg;
                            stateR        <= WAIT_MEM;
                        end else begin
                            WbValid     <= 1'b1;
                            WbWriteData <= selDataS;
                            WbWriteReg  <= WriteReg;
                            WbRegWrite  <= RegWrite && (WriteReg != {REG_ADDR_WIDTH{1'b0}});
                        end
                    end
                end
                WAIT_MEM: begin
                    if (Flush) begin
                        stateR <= IDLE;
                    end else if (MemReadValid) begin
                        WbValid     <= 1'b1;
                        MisalignErr <= misalignS;
                        WbWriteData <= loadDataS;
                        WbWriteReg  <= writeRegR;
                        WbRegWrite  <= regWriteR && (writeRegR != {REG_ADDR_WIDTH{1'b0}}) && !misalignS;
                        stateR      <= IDLE;
                    end
                end
                default: stateR <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_wb_writeback.md
Name: mem_wb_writeback

Overview:
Parametrised successor to the single-bit writeback mux. It is a registered MEM/WB stage that selects among four writeback sources. Load data is lane-aligned and sign- or zero-extended by size. A load stalls upstream until the data memory returns read data. Outputs drive the register-file write port and the forwarding unit.

Parameters:
DATA_WIDTH, 32, register/datapath width; must be >= 32.
REG_ADDR_WIDTH, 5, register-file address width.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
InValid  input  1  upstream presents an instruction this cycle.
InReady  output  1  stage can accept; transfer when InValid && InReady.
Flush  input  1  discard held/incoming instruction.
WbSel  input  2  00 Result, 01 ReadData (load), 10 PcPlus4, 11 Imm.
LoadSize  input  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as word).
LoadUnsigned  input  1  1 = zero-extend, 0 = sign-extend.
ByteOffset  input  2  low address bits of load.
Result  input  DATA_WIDTH  ALU result.
PcPlus4  input  DATA_WIDTH  link value.
Imm  input  DATA_WIDTH  immediate/LUI value.
RegWrite  input  1  instruction writes a register.
WriteReg  input  REG_ADDR_WIDTH  destination register.
MemReadValid  input  1  ReadData valid strobe from data memory.
ReadData  input  DATA_WIDTH  memory read data; bits [31:0] used.
WbValid  output  1  one-cycle pulse: writeback beat.
WbRegWrite  output  1  register-file write enable (qualified by WbValid).
WbWriteReg  output  REG_ADDR_WIDTH  destination register.
WbWriteData  output  DATA_WIDTH  data to write.
MisalignErr  output  1  one-cycle pulse with WbValid on misaligned load.

Behaviour:
- States: IDLE, WAIT_MEM. Reset enters IDLE and clears all outputs: WbValid 0, WbRegWrite 0, WbWriteReg 0, WbWriteData 0, MisalignErr 0. Held capture registers are also cleared.
- InReady = (state == IDLE) && !rst. It is combinational from state only.
- IDLE, transfer with WbSel != 01: on the next edge, WbValid=1 and WbWriteData = the selected source. Latency is 1 cycle, and back-to-back transfers give one WbValid per cycle.
- IDLE, transfer with WbSel == 01: capture control fields, go to WAIT_MEM, and emit no WbValid. MemReadValid is ignored in the capture cycle.
- WAIT_MEM: hold until MemReadValid=1. On that edge, WbValid=1 with the extracted data and state returns to IDLE. InReady stays 0 throughout WAIT_MEM, including the MemReadValid cycle.
- Load extraction (D = ReadData[31:0]):
  - byte: D[8*ByteOffset +: 8].
  - half: D[16*ByteOffset[1] +: 16].
  - word: D.
  - Extend to DATA_WIDTH: sign-extend if LoadUnsigned=0, else zero-extend. Word loads also extend when DATA_WIDTH > 32.
- Misalignment (half with ByteOffset[0]=1, or word with ByteOffset != 0): WbValid=1 and MisalignErr=1. WbRegWrite is forced 0, and WbWriteData still carries the extracted value.
- Zero register: WbRegWrite = RegWrite && (WriteReg != 0) && !misaligned. WbWriteReg is always passed through.
- WbValid and MisalignErr are single-cycle pulses. WbRegWrite, WbWriteReg and WbWriteData hold their last values when WbValid=0.
- Flush in IDLE: suppresses capture of an InValid in the same cycle (Flush wins), and no WbValid follows.
- Flush in WAIT_MEM: abandon the load and return to IDLE. A concurrent MemReadValid is ignored and no WbValid is produced.
- rst asserted mid-WAIT_MEM: immediate return to IDLE with outputs cleared. A later MemReadValid is ignored.
- MemReadValid in IDLE: ignored.

Test Plan:
- Reset: assert rst -> all outputs 0, InReady=0. Release -> InReady=1.
- ALU path: WbSel=00, Result=0x00000101, RegWrite=1, WriteReg=8 -> next cycle WbValid=1, WbWriteData=0x00000101, WbRegWrite=1, WbWriteReg=8. Back-to-back PcPlus4=0x00400008 then Imm=0x12340000 -> consecutive WbValid pulses with those values.
- Byte loads: WbSel=01, LoadSize=00, ByteOffset=2, LoadUnsigned=0. MemReadValid 3 cycles later with ReadData=0x0080FF00 -> InReady=0 for 4 cycles, then WbWriteData=0xFFFFFF80. Same with LoadUnsigned=1 -> 0x00000080.
- Half/word loads: half at offset 2 of 0x8001_0100 -> signed 0xFFFF8001. Word at offset 0 of 0x00000100 -> 0x00000100.
- Misaligned: half at offset 1 -> WbValid=1, MisalignErr=1, WbRegWrite=0.
- Zero register and control:
  - WriteReg=0, RegWrite=1 -> WbRegWrite=0.
  - Flush during WAIT_MEM together with MemReadValid -> no WbValid, InReady=1 next cycle.
  - rst mid-WAIT_MEM -> outputs 0, later MemReadValid ignored.
